// File: rtl/aes_key_expand_pkg.sv
// rtl/aes_key_expand_pkg.sv - shared AES-128 key schedule constants, state type and helpers
`timescale 1ns/1ps
package aes_key_expand_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // Round constant for round i (1..10); zero outside that range
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Byte 0 sits in bits [7:0]; rotating {b0,b1,b2,b3} to {b1,b2,b3,b0}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[7:0], w[31:8]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
`timescale 1ns/1ps
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0 occupies the top byte, so entry x lives at [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX_LUT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX_LUT[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 round-key generator with per-entry valid store
`timescale 1ns/1ps
module aes_key_expand
    import aes_key_expand_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          k_ready,
    input  logic [KW-1:0] Cipher_Key,
    input  logic [3:0]    Addr,
    output logic [KW:0]   Key,
    output logic          Kexp_Busy,
    output logic          k_done
);

    state_t        state;
    logic [3:0]    rnd;
    logic [KW-1:0] rk [0:NR];
    logic [NR:0]   vld;

    logic [KW-1:0] prev_rk;
    logic [KW-1:0] next_rk;
    logic [31:0]   rot_w;
    logic [31:0]   sub_w;
    logic [31:0]   t_w;
    logic [31:0]   n0, n1, n2, n3;

    // Operand of the shared round datapath: the previous round key rk[rnd-1]
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i <= NR; i++) begin
            if (4'(i) == rnd - 4'd1) prev_rk = rk[i];
        end
    end

    assign rot_w = rot_word(prev_rk[127:96]);

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sub
            aes_sbox u_sbox (
                .din  (rot_w[8*b +: 8]),
                .dout (sub_w[8*b +: 8])
            );
        end
    endgenerate

    assign t_w     = sub_w ^ {24'h0, rcon(rnd)};
    assign n0      = prev_rk[31:0]   ^ t_w;
    assign n1      = prev_rk[63:32]  ^ n0;
    assign n2      = prev_rk[95:64]  ^ n1;
    assign n3      = prev_rk[127:96] ^ n2;
    assign next_rk = {n3, n2, n1, n0};

    // Load/expand sequencer: one round key per clock, valid flag set as each key lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rnd       <= '0;
            vld       <= '0;
            Kexp_Busy <= 1'b0;
            k_done    <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            k_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (k_ready) begin
                        rk[0]     <= Cipher_Key;
                        vld       <= {{NR{1'b0}}, 1'b1};
                        rnd       <= 4'd1;
                        Kexp_Busy <= 1'b1;
                        state     <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (4'(i) == rnd) begin
                            rk[i]  <= next_rk;
                            vld[i] <= 1'b1;
                        end
                    end
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'(NR)) begin
                        Kexp_Busy <= 1'b0;
                        k_done    <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency read port; indices beyond the store read as all zeros
    always_comb begin
        Key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (4'(i) == Addr) Key = {vld[i], rk[i]};
        end
    end

endmodule
